// File: rtl/tick_enable_scheduler_pkg.sv
// Shared constants and FSM encoding for the
// tick-enable scheduler and its channels.
package tick_enable_scheduler_pkg;

  localparam int NCH     = 4;
  localparam int DIV_W   = 26;
  localparam int DEF_DIV = 131072;
  localparam int MIN_DIV = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BND,
    DONE
  } state_e;

endpackage

// File: rtl/tick_channel.sv
// One strobe channel: free-running modulo counter
// with a registered single-cycle tick on wrap.
module tick_channel #(
  parameter int DIV_W   = 26,
  parameter int DEF_DIV = 131072
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             load_i,
  input  logic             sync_i,
  output logic             en_o,
  output logic             wrap_o,
  output logic             tick_o
);

  logic             en_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             tick_q;

  // div_q >= 2 always, so div_q-1 never underflows
  assign wrap_o = en_q && (cnt_q == div_q - DIV_W'(1));
  assign en_o   = en_q;
  assign tick_o = tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b1;
      div_q  <= DIV_W'(DEF_DIV);
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= wrap_o && !sync_i;
      if (load_i) begin
        en_q  <= en_i;
        div_q <= div_i;
        cnt_q <= '0;
      end else if (sync_i || wrap_o || !en_q) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/tick_enable_scheduler.sv
// Multi-channel clock-enable scheduler; config changes
// to a running channel are deferred to its wrap.
module tick_enable_scheduler
  import tick_enable_scheduler_pkg::*;
#(
  parameter int NCH     = tick_enable_scheduler_pkg::NCH,
  parameter int DIV_W   = tick_enable_scheduler_pkg::DIV_W,
  parameter int DEF_DIV = tick_enable_scheduler_pkg::DEF_DIV,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_en,
  input  logic             sync_req,
  output logic [NCH-1:0]   tick,
  output logic             busy,
  output logic             cfg_err
);

  localparam int CHP = 2 ** CH_W;

  state_e           state_q, state_d;
  logic             ready_q, busy_q, err_q, err_d;
  logic [CH_W-1:0]  pend_ch_q;
  logic [DIV_W-1:0] pend_div_q;
  logic             pend_en_q;

  logic [NCH-1:0]   ch_en, wrap, load;
  logic [CHP-1:0]   en_p, wrap_p, load_p, ch_ok;
  logic [DIV_W-1:0] ld_div;
  logic             ld_en;
  logic             hs, cfg_bad;

  // Pad per-channel vectors to the full index range
  always_comb begin
    en_p   = '0;
    wrap_p = '0;
    ch_ok  = '0;
    for (int i = 0; i < NCH; i++) begin
      en_p[i]   = ch_en[i];
      wrap_p[i] = wrap[i];
      ch_ok[i]  = 1'b1;
    end
  end

  assign hs      = cfg_valid && ready_q;
  assign cfg_bad = (cfg_div < DIV_W'(MIN_DIV))
                || !ch_ok[cfg_ch];

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    load_p  = '0;
    ld_div  = cfg_div;
    ld_en   = cfg_en;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          if (cfg_bad) begin
            err_d = 1'b1;
          end else if (!en_p[cfg_ch] || !cfg_en
                       || sync_req) begin
            load_p[cfg_ch] = 1'b1;
            state_d        = DONE;
          end else begin
            state_d = WAIT_BND;
          end
        end
      end
      WAIT_BND: begin
        if (wrap_p[pend_ch_q] || sync_req) begin
          load_p[pend_ch_q] = 1'b1;
          ld_div            = pend_div_q;
          ld_en             = pend_en_q;
          state_d           = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign load = load_p[NCH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      pend_en_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d == WAIT_BND);
      err_q   <= err_d;
      if (state_q == IDLE && hs && !cfg_bad) begin
        pend_ch_q  <= cfg_ch;
        pend_div_q <= cfg_div;
        pend_en_q  <= cfg_en;
      end
    end
  end

  assign cfg_ready = ready_q;
  assign busy      = busy_q;
  assign cfg_err   = err_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    tick_channel #(
      .DIV_W  (DIV_W),
      .DEF_DIV(DEF_DIV)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (ld_en),
      .div_i (ld_div),
      .load_i(load[g]),
      .sync_i(sync_req),
      .en_o  (ch_en[g]),
      .wrap_o(wrap[g]),
      .tick_o(tick[g])
    );
  end

endmodule

// File: tb/tb_tick_enable_scheduler.sv
// Bench for tick_enable_scheduler: directed steps plus
// random traffic against a period/anchor reference model.
module tb_tick_enable_scheduler;

  localparam int NCH     = 3;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 24;
  localparam int CH_W    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_en = 1'b0;
  logic             sync_req = 1'b0;
  logic [NCH-1:0]   tick;
  logic             busy;
  logic             cfg_err;

  tick_enable_scheduler #(
    .NCH    (NCH),
    .DIV_W  (DIV_W),
    .DEF_DIV(DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_en   (cfg_en),
    .sync_req (sync_req),
    .tick     (tick),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a channel ticks at edge n when enabled and
  // n lies a whole number of periods after its anchor.
  int             n;
  bit             m_en  [NCH];
  int             m_div [NCH];
  int             m_t0  [NCH];
  int             mode;
  int             p_ch, p_div;
  bit             p_en;
  logic [NCH-1:0] e_tick;
  bit             e_busy, e_ready, e_err;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0t got %0h exp %0h",
             tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    n    = 0;
    mode = 0;
    for (int i = 0; i < NCH; i++) begin
      m_en[i]  = 1'b1;
      m_div[i] = DEF_DIV;
      m_t0[i]  = 0;
    end
    e_tick  = '0;
    e_busy  = 1'b0;
    e_ready = 1'b1;
    e_err   = 1'b0;
  endtask

  task automatic apply(int ch, int dv, bit en);
    m_en[ch]  = en;
    m_div[ch] = dv;
    m_t0[ch]  = n;
  endtask

  task automatic m_edge(bit v, int ch, int dv, bit en,
                        bit sy);
    bit nat [NCH];
    n++;
    for (int i = 0; i < NCH; i++) begin
      nat[i] = m_en[i] && (n > m_t0[i])
            && (((n - m_t0[i]) % m_div[i]) == 0);
      e_tick[i] = nat[i] && !sy;
    end
    e_err = 1'b0;
    case (mode)
      0: if (v) begin
        if (dv < 2 || ch >= NCH) begin
          e_err = 1'b1;
        end else if (!m_en[ch] || !en || sy) begin
          apply(ch, dv, en);
          mode = 2;
        end else begin
          p_ch  = ch;
          p_div = dv;
          p_en  = en;
          mode  = 1;
        end
      end
      1: if (nat[p_ch] || sy) begin
        apply(p_ch, p_div, p_en);
        mode = 2;
      end
      default: mode = 0;
    endcase
    if (sy)
      for (int i = 0; i < NCH; i++)
        if (m_en[i]) m_t0[i] = n;
    e_ready = (mode == 0);
    e_busy  = (mode == 1);
  endtask

  task automatic step(bit v = 0, int ch = 0, int dv = 0,
                      bit en = 0, bit sy = 0);
    cfg_valid = v;
    cfg_ch    = ch[CH_W-1:0];
    cfg_div   = dv[DIV_W-1:0];
    cfg_en    = en;
    sync_req  = sy;
    @(posedge clk);
    m_edge(v, ch, dv, en, sy);
    #1;
    chk("tick", 32'(tick), 32'(e_tick));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("ready", 32'(cfg_ready), 32'(e_ready));
    chk("err", 32'(cfg_err), 32'(e_err));
  endtask

  task automatic idle(int k);
    repeat (k) step();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (mode != 0 && g < 600) begin
      step();
      g++;
    end
    chk("wait_budget", 32'(g < 600), 32'd1);
  endtask

  task automatic req(int ch, int dv, bit en,
                     bit sy = 0);
    wait_idle();
    step(1'b1, ch, dv, en, sy);
  endtask

  initial begin
    bit v, en, sy;
    int ch, dv;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;

    idle(100);
    req(0, 10, 1'b1);
    idle(45);

    req(1, 1, 1'b1);
    req(1, 0, 1'b1);
    req(3, 5, 1'b1);
    idle(3);

    req(2, 6, 1'b0);
    idle(12);
    req(2, 4, 1'b1);
    idle(20);

    req(1, 7, 1'b1);
    wait_idle();
    idle(10);
    req(1, 5, 1'b1);
    step();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    idle(25);

    req(0, 255, 1'b1);
    wait_idle();
    idle(520);

    req(2, 3, 1'b1, 1'b1);
    idle(10);

    req(0, 9, 1'b1);
    step();
    step();
    chk("mid_wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    sync_req  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_reset();
    idle(60);

    for (int k = 0; k < 4000; k++) begin
      v  = 1'b0;
      ch = 0;
      dv = 0;
      en = 1'b0;
      sy = ($urandom_range(0, 49) == 0);
      if (mode == 0 && $urandom_range(0, 3) == 0) begin
        v  = 1'b1;
        ch = int'($urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0:       dv = int'($urandom_range(0, 1));
          1:       dv = 255;
          default: dv = int'($urandom_range(2, 12));
        endcase
        en = ($urandom_range(0, 4) != 0);
      end
      step(v, ch, dv, en, sy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
